// File: rtl/cond_unit.sv
// cond_unit
// Conditional-execution unit for the multi-cycle ARM datapath. It holds
// NUM_BANKS banked NZCV flag registers and evaluates the 4-bit condition
// field against the selected bank. It latches the result (CondEx) for the
// rest of the instruction and gates the PC, register-file, memory and flag
// write enables. An IT-style sequencer can override the condition field for
// up to IT_MAX following instructions.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   Cond       in   [3:0] instruction condition field
//   ALUFlags   in   [3:0] {N,Z,C,V} from the ALU
//   FlagW      in   [1:0] bit1: write N,Z  bit0: write C,V
//   BankSel    in   [BS_W-1:0] flag bank for evaluation and write
//   CondLatch  in   capture the evaluated condition into CondEx
//   PCS/RegW/MemW in ungated write requests
//   NextPC     in   unconditional PC write
//   InstrDone  in   retire strobe, advances the IT slot
//   ITStart    in   load an IT block (ITCond, ITLen, ITPattern)
//   CondEx     out  registered condition result
//   PCWrite/RegWrite/MemWrite out gated enables
//   Flags      out  [3:0] NZCV of the selected bank
//   ITActive   out  IT block in progress
module cond_unit #(
    parameter int NUM_BANKS = 2,
    parameter int IT_MAX    = 4,
    localparam int BS_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      Cond,
    input  logic [3:0]      ALUFlags,
    input  logic [1:0]      FlagW,
    input  logic [BS_W-1:0] BankSel,
    input  logic            CondLatch,
    input  logic            PCS,
    input  logic            RegW,
    input  logic            MemW,
    input  logic            NextPC,
    input  logic            InstrDone,
    input  logic            ITStart,
    input  logic [3:0]      ITCond,
    input  logic [1:0]      ITLen,
    input  logic [3:0]      ITPattern,
    output logic            CondEx,
    output logic            PCWrite,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic [3:0]      Flags,
    output logic            ITActive
);

    localparam logic [1:0] LEN_MAX = 2'(IT_MAX - 1);

    typedef enum logic {
        IT_IDLE,
        IT_ACTIVE
    } it_state_e;

    it_state_e       it_state_q;
    logic [1:0]      it_slot_q;
    logic [1:0]      it_len_q;
    logic [3:0]      it_cond_q;
    logic [3:0]      it_pat_q;
    logic            cond_ex_q;
    logic            cond_ex_d;
    logic [3:0]      bank_q [NUM_BANKS];

    logic [BS_W-1:0] bank_idx;
    logic [3:0]      sel_flags;
    logic [3:0]      eff_cond;
    logic [1:0]      it_len_clamped;

    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    eval_cond = z;
            4'h1:    eval_cond = ~z;
            4'h2:    eval_cond = cf;
            4'h3:    eval_cond = ~cf;
            4'h4:    eval_cond = n;
            4'h5:    eval_cond = ~n;
            4'h6:    eval_cond = v;
            4'h7:    eval_cond = ~v;
            4'h8:    eval_cond = cf & ~z;
            4'h9:    eval_cond = ~cf | z;
            4'hA:    eval_cond = (n == v);
            4'hB:    eval_cond = (n != v);
            4'hC:    eval_cond = ~z & (n == v);
            4'hD:    eval_cond = z | (n != v);
            default: eval_cond = 1'b1;   // AL and the unconditional space
        endcase
    endfunction

    // Out-of-range bank selects alias to bank 0.
    always_comb begin
        bank_idx = '0;
        if (32'(BankSel) < NUM_BANKS) begin
            bank_idx = BankSel;
        end
    end

    assign sel_flags = bank_q[bank_idx];

    // Inside an IT block the stored pattern picks the then/else condition.
    // An else slot inverts bit 0, except for 111x which must stay "always".
    always_comb begin
        eff_cond = Cond;
        if (it_state_q == IT_ACTIVE) begin
            eff_cond = it_cond_q;
            if (!it_pat_q[it_slot_q] && (it_cond_q[3:1] != 3'b111)) begin
                eff_cond = {it_cond_q[3:1], ~it_cond_q[0]};
            end
        end
    end

    assign it_len_clamped = (ITLen > LEN_MAX) ? LEN_MAX : ITLen;

    always_comb begin
        cond_ex_d = cond_ex_q;
        if (CondLatch) begin
            cond_ex_d = eval_cond(eff_cond, sel_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cond_ex_q <= 1'b0;
        end else begin
            cond_ex_q <= cond_ex_d;
        end
    end

    // Flag writes are qualified by the CondEx already held, not the value
    // being latched in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= '0;
            end
        end else begin
            if (FlagW[1] && cond_ex_q) begin
                bank_q[bank_idx][3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0] && cond_ex_q) begin
                bank_q[bank_idx][1:0] <= ALUFlags[1:0];
            end
        end
    end

    // IT sequencer; ITStart wins over a same-cycle InstrDone.
    always_ff @(posedge clk) begin
        if (reset) begin
            it_state_q <= IT_IDLE;
            it_slot_q  <= '0;
            it_len_q   <= '0;
            it_cond_q  <= '0;
            it_pat_q   <= '0;
        end else if (ITStart) begin
            it_state_q <= IT_ACTIVE;
            it_slot_q  <= '0;
            it_len_q   <= it_len_clamped;
            it_cond_q  <= ITCond;
            it_pat_q   <= ITPattern;
        end else if ((it_state_q == IT_ACTIVE) && InstrDone) begin
            if (it_slot_q == it_len_q) begin
                it_state_q <= IT_IDLE;
                it_slot_q  <= '0;
            end else begin
                it_slot_q  <= it_slot_q + 2'd1;
            end
        end
    end

    assign CondEx   = cond_ex_q;
    assign PCWrite  = (PCS & cond_ex_q) | NextPC;
    assign RegWrite = RegW & cond_ex_q;
    assign MemWrite = MemW & cond_ex_q;
    assign Flags    = sel_flags;
    assign ITActive = (it_state_q == IT_ACTIVE);

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

    localparam int NB  = 2;
    localparam int ITM = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, ALUFlags, ITCond, ITPattern;
    logic [1:0] FlagW, ITLen;
    logic [0:0] BankSel;
    logic       CondLatch, PCS, RegW, MemW, NextPC, InstrDone, ITStart;
    logic       CondEx, PCWrite, RegWrite, MemWrite, ITActive;
    logic [3:0] Flags;

    int checks = 0;
    int errors = 0;

    // Reference model state: flag banks, latched condition, and the list of
    // effective conditions still pending in the current IT block.
    logic [3:0] m_bank [NB];
    logic       m_condex;
    logic [3:0] m_itq [$];

    cond_unit #(.NUM_BANKS(NB), .IT_MAX(ITM)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .BankSel(BankSel), .CondLatch(CondLatch),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NextPC(NextPC),
        .InstrDone(InstrDone), .ITStart(ITStart), .ITCond(ITCond),
        .ITLen(ITLen), .ITPattern(ITPattern), .CondEx(CondEx),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Flags(Flags), .ITActive(ITActive)
    );

    always #5 clk = ~clk;

    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cf;
            3:  return !cf;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cf && !z;
            9:  return !cf || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic int bank_of(input logic [0:0] s);
        return (int'(s) < NB) ? int'(s) : 0;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] ef;
        ef = m_bank[bank_of(BankSel)];
        chk({tag, "_condex"}, {3'b0, CondEx}, {3'b0, m_condex});
        chk({tag, "_pcw"}, {3'b0, PCWrite}, {3'b0, (PCS & m_condex) | NextPC});
        chk({tag, "_regw"}, {3'b0, RegWrite}, {3'b0, RegW & m_condex});
        chk({tag, "_memw"}, {3'b0, MemWrite}, {3'b0, MemW & m_condex});
        chk({tag, "_flags"}, Flags, ef);
        chk({tag, "_itact"}, {3'b0, ITActive}, {3'b0, m_itq.size() != 0});
    endtask

    task automatic model_edge();
        logic       old_cx;
        int         b;
        int         len;
        logic [3:0] c;
        if (reset) begin
            for (int i = 0; i < NB; i++) m_bank[i] = 4'h0;
            m_condex = 1'b0;
            m_itq.delete();
        end else begin
            old_cx = m_condex;
            b = bank_of(BankSel);
            if (CondLatch)
                m_condex = ref_eval((m_itq.size() != 0) ? m_itq[0] : Cond, m_bank[b]);
            if (FlagW[1] && old_cx) m_bank[b][3:2] = ALUFlags[3:2];
            if (FlagW[0] && old_cx) m_bank[b][1:0] = ALUFlags[1:0];
            if (ITStart) begin
                m_itq.delete();
                len = (int'(ITLen) > ITM - 1) ? ITM - 1 : int'(ITLen);
                for (int i = 0; i <= len; i++) begin
                    if (ITPattern[i] || ITCond[3:1] == 3'b111) c = ITCond;
                    else c = ITCond ^ 4'b0001;
                    m_itq.push_back(c);
                end
            end else if (InstrDone && m_itq.size() != 0) begin
                void'(m_itq.pop_front());
            end
        end
    endtask

    // Check the current cycle, advance the model, then cross the edge.
    task automatic cyc(input string tag);
        #1;
        check_all(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; Cond = 4'hE; ALUFlags = 0; FlagW = 0; BankSel = 0;
        CondLatch = 0; PCS = 0; RegW = 0; MemW = 0; NextPC = 0;
        InstrDone = 0; ITStart = 0; ITCond = 0; ITLen = 0; ITPattern = 0;
    endtask

    // Load flags f into bank bs: latch AL, then write both halves.
    task automatic load_flags(input logic [0:0] bs, input logic [3:0] f);
        idle(); BankSel = bs; CondLatch = 1; Cond = 4'hE; cyc("ld_al");
        idle(); BankSel = bs; ALUFlags = f; FlagW = 2'b11; cyc("ld_wr");
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        cyc("rst");
        cyc("rst2");
        idle();
        #1;
        chk("reset_condex", {3'b0, CondEx}, 4'h0);
        chk("reset_flags", Flags, 4'h0);
        chk("reset_itact", {3'b0, ITActive}, 4'h0);
        NextPC = 1; #1;
        chk("reset_pcw_nextpc", {3'b0, PCWrite}, 4'h1);
        idle();

        // EQ with Z=0, then force CondEx=1 and write Z.
        Cond = 4'h0; CondLatch = 1; cyc("eq0");
        chk("eq_z0", {3'b0, CondEx}, 4'h0);
        idle(); Cond = 4'hE; CondLatch = 1; cyc("al");
        idle(); ALUFlags = 4'b0100; FlagW = 2'b11; cyc("wrz");
        idle(); #1;
        chk("flags_0100", Flags, 4'b0100);
        Cond = 4'h0; CondLatch = 1; cyc("eq1");
        chk("eq_z1", {3'b0, CondEx}, 4'h1);

        // Full decode sweep.
        for (int f = 0; f < 16; f++) begin
            load_flags(1'b0, 4'(f));
            for (int c = 0; c < 16; c++) begin
                idle(); Cond = 4'(c); CondLatch = 1; cyc("sweep_lat");
                idle(); cyc("sweep_hold");
                if (c >= 14) chk("sweep_al", {3'b0, CondEx}, 4'h1);
            end
        end

        // CondEx=0 blocks all gated writes including flags.
        load_flags(1'b0, 4'b0000);
        idle(); Cond = 4'h0; CondLatch = 1; cyc("cx0");
        idle(); PCS = 1; RegW = 1; MemW = 1; FlagW = 2'b11; ALUFlags = 4'hF; cyc("gated");
        idle(); #1;
        chk("gated_flags_kept", Flags, 4'h0);
        PCS = 1; NextPC = 1; cyc("nextpc");

        // Bank isolation.
        load_flags(1'b1, 4'b1000);
        idle(); BankSel = 0; #1;
        chk("bank0_clean", Flags, 4'h0);
        BankSel = 1; Cond = 4'h4; CondLatch = 1; cyc("mi_b1");
        chk("mi_bank1", {3'b0, CondEx}, 4'h1);
        idle(); BankSel = 0; Cond = 4'h4; CondLatch = 1; cyc("mi_b0");
        chk("mi_bank0", {3'b0, CondEx}, 4'h0);

        // IT block: EQ, pattern 0101, three slots with Z=1.
        load_flags(1'b0, 4'b0100);
        idle(); ITStart = 1; ITCond = 4'h0; ITLen = 2; ITPattern = 4'b0101; cyc("its");
        for (int s = 0; s < 3; s++) begin
            idle(); Cond = 4'h1; CondLatch = 1; cyc("it_lat");
            chk("it_slot", {3'b0, CondEx}, (s == 1) ? 4'h0 : 4'h1);
            idle(); InstrDone = 1; cyc("it_done");
        end
        chk("it_drop", {3'b0, ITActive}, 4'h0);
        idle(); Cond = 4'h1; CondLatch = 1; cyc("post_it");
        chk("post_it_cond", {3'b0, CondEx}, 4'h0);

        // Restart mid-block with a same-cycle InstrDone, then reset mid-block.
        idle(); ITStart = 1; ITCond = 4'h1; ITLen = 3; ITPattern = 4'b0000; cyc("its2");
        idle(); CondLatch = 1; cyc("s0"); idle(); InstrDone = 1; cyc("d0");
        idle(); ITStart = 1; InstrDone = 1; ITCond = 4'h0; ITLen = 1; ITPattern = 4'b0001; cyc("restart");
        idle(); CondLatch = 1; Cond = 4'h1; cyc("rs_s0");
        chk("restart_slot0", {3'b0, CondEx}, 4'h1);
        idle(); reset = 1; cyc("midrst");
        idle(); #1;
        chk("midrst_itact", {3'b0, ITActive}, 4'h0);
        chk("midrst_condex", {3'b0, CondEx}, 4'h0);
        chk("midrst_flags", Flags, 4'h0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            Cond      = 4'($urandom);
            ALUFlags  = 4'($urandom);
            FlagW     = 2'($urandom);
            BankSel   = 1'($urandom);
            CondLatch = 1'($urandom);
            PCS       = 1'($urandom);
            RegW      = 1'($urandom);
            MemW      = 1'($urandom);
            NextPC    = 1'($urandom);
            InstrDone = ($urandom_range(0, 3) == 0);
            ITStart   = ($urandom_range(0, 11) == 0);
            ITCond    = 4'($urandom);
            ITLen     = 2'($urandom);
            ITPattern = 4'($urandom);
            cyc("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Parametrised conditional-execution unit for the multi-cycle ARM datapath; it sits between the control FSM and the datapath write enables. It holds the banked NZCV flag registers and evaluates the 4-bit condition field against them. It latches the result for the rest of the instruction and gates the PC, register-file, memory and flag write enables. It adds an IT-style predication sequencer that overrides the condition field for up to IT_MAX following instructions.

## Interface
- NUM_BANKS, 2: number of independent NZCV flag banks (≥1); BS_W = max(1, $clog2(NUM_BANKS)).
- IT_MAX, 4: maximum IT block length (1..4).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Cond  in  4  instruction condition field.
- ALUFlags  in  4  {N,Z,C,V} from ALU.
- FlagW  in  2  bit1 → write N,Z; bit0 → write C,V.
- BankSel  in  BS_W  selects the flag bank for evaluation and write; values ≥ NUM_BANKS map to bank 0.
- CondLatch  in  1  decode strobe; capture the evaluated condition.
- PCS, RegW, MemW  in  1 each  ungated write requests from the control FSM.
- NextPC  in  1  unconditional PC write (fetch).
- InstrDone  in  1  retire strobe, one cycle per instruction.
- ITStart  in  1  load an IT block.
- ITCond  in  4  IT base condition.
- ITLen  in  2  block length minus 1; clamped to IT_MAX-1.
- ITPattern  in  4  bit i: 1 = "then" (ITCond), 0 = "else" for slot i.
- CondEx  out  1  registered condition result.
- PCWrite, RegWrite, MemWrite  out  1 each  gated enables.
- Flags  out  4  current {N,Z,C,V} of the selected bank.
- ITActive  out  1  IT block in progress.

## Operation
- Condition decode:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 is unconditional (1).
- Effective condition:
  - ITActive=0: Cond.
  - ITActive=1, slot k: ITCond if ITPattern[k]=1. Otherwise {ITCond[3:1], ~ITCond[0]}.
  - An "else" on an ITCond of 111x stays 1 (no inversion).
- CondLatch=1: CondEx ← eval(effective cond, Flags[BankSel]), using pre-edge flags.
- Gated outputs:
  - PCWrite = (PCS & CondEx) | NextPC.
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
- Flag write, per half, at the edge:
  - FlagW[1] & CondEx: bank[BankSel][3:2] ← ALUFlags[3:2].
  - FlagW[0] & CondEx: bank[BankSel][1:0] ← ALUFlags[1:0].
  - Other banks are never touched.
- IT FSM:
  - IDLE --ITStart--> ACTIVE: slot←0, len←min(ITLen, IT_MAX-1), latch ITCond/ITPattern.
  - ACTIVE --InstrDone & slot==len--> IDLE.
  - ACTIVE --InstrDone--> slot+1.
  - ITStart in ACTIVE restarts the block with new values; it takes priority over a same-cycle InstrDone.
  - ITStart itself does not advance a slot.
- Reset values: CondEx=0, all banks 0000, IT state IDLE, slot=0.
  - Hence PCWrite=NextPC, RegWrite=0, MemWrite=0, Flags=0000, ITActive=0.
- Reset has priority over all inputs; reset during an IT block returns to IDLE.

## Timing
- CondEx is valid the cycle after CondLatch. It holds until the next CondLatch or reset.
- Gated enables are combinational from CondEx and the request inputs; there is no added latency.
- Flag writes are visible on Flags the cycle after the write.
- If CondLatch and a flag write coincide, evaluation sees the old flags and CondEx for the write uses the old CondEx.
- ITActive rises the cycle after ITStart. It falls the cycle after the final InstrDone.
- Slot advance takes effect for the next CondLatch.
- BankSel is sampled combinationally for both evaluation and write.

## Test plan
- Reset, then Cond=0000 with CondLatch → CondEx=0 (Z=0). Then ALUFlags=0100, FlagW=11, CondEx forced to 1 via Cond=1110 latch → Flags=0100 next cycle. Then EQ latch → CondEx=1.
- Sweep all 16 Cond × 16 flag values → CondEx matches the decode list. Check 1111 and 1110 always give 1.
- CondEx=0 with PCS=RegW=MemW=1, FlagW=11 → PCWrite=0, RegWrite=0, MemWrite=0, flags unchanged. Repeat with NextPC=1 → PCWrite=1.
- NUM_BANKS=2: write 1000 into bank 1 → bank 0 reads 0000. BankSel=1 with MI → CondEx=1; BankSel=0 with MI → CondEx=0.
- ITStart, ITCond=0000, ITLen=2, ITPattern=0101, Z=1 → three slots give CondEx=1,0,1 regardless of Cond. ITActive drops after the 3rd InstrDone. Next instruction uses Cond.
- ITStart mid-block with the same-cycle InstrDone → restarts at slot 0. Reset mid-block → ITActive=0, CondEx=0, flags 0000 next cycle.
